// File: rtl/dm_resp.sv
// ============================================================================
// Module   : dm_resp
// Purpose  : Single-port data memory responder, IDLE/WAIT/RESP handshake,
//            byte-lane writes, range/byte-enable error reporting and write log.
//            Optional wait states enabled by macro DM_WAIT_STATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_resp #(
    parameter int DEPTH = 4096,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    input  logic [31:0] pc,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

`ifdef DM_WAIT_STATE_EN
    localparam int NWAIT = WAIT;
`else
    localparam int NWAIT = 0;
    localparam int c_unused_wait = WAIT;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (NWAIT > 1) ? $clog2(NWAIT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt, w_cnt_next;

    logic           r_we;
    logic [29:0]    r_waddr;
    logic [31:0]    r_wdata;
    logic [3:0]     r_byteen;
    logic [31:0]    r_pc;

    logic [31:0]    r_mem [DEPTH];

    logic           w_idle, w_we, w_oob, w_be_ok, w_err, w_enter;
    logic [29:0]    w_waddr;
    logic [31:0]    w_wdata, w_pc, w_word, w_merged;
    logic [3:0]     w_byteen;
    logic [AW-1:0]  w_idx;
    logic           w_unused;

    assign w_unused = &{1'b0, addr[1:0]};

    // With no wait states the commit happens on the accept edge itself, so the
    // live inputs are used there; otherwise the latched copy is used.
    assign w_idle   = (r_state == S_IDLE);
    assign w_we     = w_idle ? we          : r_we;
    assign w_waddr  = w_idle ? addr[31:2]  : r_waddr;
    assign w_wdata  = w_idle ? wdata       : r_wdata;
    assign w_byteen = w_idle ? byteen      : r_byteen;
    assign w_pc     = w_idle ? pc          : r_pc;

    assign w_idx   = w_waddr[AW-1:0];
    assign w_word  = r_mem[w_idx];
    assign w_oob   = ({3'b000, w_waddr} >= 33'(DEPTH));
    assign w_be_ok = (w_byteen == 4'b1111) || (w_byteen == 4'b0011) ||
                     (w_byteen == 4'b1100) || (w_byteen == 4'b0001) ||
                     (w_byteen == 4'b0010) || (w_byteen == 4'b0100) ||
                     (w_byteen == 4'b1000);
    assign w_err   = w_oob || (w_we && !w_be_ok);
    assign w_enter = (w_next == S_RESP) && (r_state != S_RESP);

    always_comb begin
        w_merged = w_word;
        for (int b = 0; b < 4; b++) begin
            if (w_byteen[b]) begin
                w_merged[8*b +: 8] = w_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    if (NWAIT == 0) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = CW'(NWAIT);
                    end
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            ready    <= 1'b0;
            rdata    <= 32'h0;
            err      <= 1'b0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= 32'h0;
            r_byteen <= 4'h0;
            r_pc     <= 32'h0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            ready   <= w_enter;
            if (w_idle && req) begin
                r_we     <= we;
                r_waddr  <= addr[31:2];
                r_wdata  <= wdata;
                r_byteen <= byteen;
                r_pc     <= pc;
            end
            if (w_enter) begin
                err <= w_err;
                if (w_err) begin
                    rdata <= 32'h0;
                end else if (w_we) begin
                    rdata        <= w_merged;
                    r_mem[w_idx] <= w_merged;
                end else begin
                    rdata <= w_word;
                end
            end else begin
                err <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && w_enter && w_we && !w_err) begin
            $display("@%08h: *%08h <= %08h", w_pc, {w_waddr, 2'b00}, w_merged);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dm_resp.sv
// ============================================================================
// Module   : tb_dm_resp
// Purpose  : Self-checking bench for dm_resp against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_resp;

    localparam int DEPTH = 4096;
    localparam int WAIT  = 2;
`ifdef DM_WAIT_STATE_EN
    localparam int NWAIT = WAIT;
`else
    localparam int NWAIT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  byteen = 4'h0;
    logic [31:0] pc = 32'h0;
    logic        ready;
    logic [31:0] rdata;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] model [DEPTH];

    dm_resp #(.DEPTH(DEPTH), .WAIT(WAIT)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .pc     (pc),
        .ready  (ready),
        .rdata  (rdata),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic bit legal_be(input logic [3:0] be);
        return be inside {4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        foreach (model[i]) model[i] = 32'h0;
    endtask

    // Model update; returns expected err and expected read word.
    task automatic model_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, output logic e, output logic [31:0] rd);
        int idx;
        e  = (a >= 32'(DEPTH * 4)) || (w && !legal_be(be));
        rd = 32'h0;
        if (!e) begin
            idx = int'(a / 4);
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                end
            end
            rd = model[idx];
        end
    endtask

    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be, input bit hold);
        int          cyc;
        logic        exp_err;
        logic [31:0] exp_rd;
        model_txn(w, a, d, be, exp_err, exp_rd);
        req = 1'b1; we = w; addr = a; wdata = d; byteen = be; pc = $urandom;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ready && cyc < 20);
        chk({tag, ".lat"}, 32'(cyc), 32'(NWAIT + 1));
        chk({tag, ".err"}, 32'(err), 32'(exp_err));
        if (!w) chk({tag, ".rdata"}, rdata, exp_rd);
        if (hold) begin
            @(negedge clk);
            chk({tag, ".gap"}, 32'(ready), 32'h0);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!ready && cyc < 20);
            chk({tag, ".lat2"}, 32'(cyc), 32'(NWAIT + 1));
            if (!w) chk({tag, ".rdata2"}, rdata, exp_rd);
        end
        req = 1'b0;
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(ready), 32'h0);
        chk({tag, ".errlow"}, 32'(err), 32'h0);
        if (!w) chk({tag, ".hold"}, rdata, exp_rd);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  be;
        do_reset();
        chk("rst.ready", 32'(ready), 32'h0);
        chk("rst.err",   32'(err),   32'h0);
        chk("rst.rdata", rdata,      32'h0);

        txn("rd0",    1'b0, 32'h0,    32'h0,        4'hF, 1'b0);
        txn("wr10",   1'b1, 32'h10,   32'h12345678, 4'hF, 1'b0);
        txn("rd10",   1'b0, 32'h10,   32'h0,        4'hF, 1'b0);
        txn("wr12",   1'b1, 32'h12,   32'h00AB0000, 4'h4, 1'b0);
        txn("rd10b",  1'b0, 32'h13,   32'h0,        4'h0, 1'b0);
        chk("merge",  rdata, 32'h12AB5678);
        txn("wrbe6",  1'b1, 32'h10,   32'hFFFFFFFF, 4'h6, 1'b0);
        txn("rd10c",  1'b0, 32'h10,   32'h0,        4'hF, 1'b0);
        txn("wroob",  1'b1, 32'h4000, 32'hDEADBEEF, 4'hF, 1'b0);
        txn("rdoob",  1'b0, 32'h4000, 32'h0,        4'hF, 1'b0);
        txn("wrtop",  1'b1, 32'h3FFC, 32'hCAFEF00D, 4'hC, 1'b0);
        txn("rdtop",  1'b0, 32'h3FFD, 32'h0,        4'hF, 1'b0);
        txn("held",   1'b0, 32'h10,   32'h0,        4'hF, 1'b1);

`ifdef DM_WAIT_STATE_EN
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF; byteen = 4'hF;
        @(negedge clk);
        reset = 1'b1;
        req   = 1'b0;
        @(negedge clk);
        chk("rstwait.ready", 32'(ready), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rstwait.ready2", 32'(ready), 32'h0);
        foreach (model[i]) model[i] = 32'h0;
        txn("rstwait.rd", 1'b0, 32'h20, 32'h0, 4'hF, 1'b0);
`endif

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0:       a = 32'h4000 + 32'($urandom_range(0, 255));
                1:       a = 32'h3FFC + 32'($urandom_range(0, 3));
                default: a = 32'($urandom_range(0, 31));
            endcase
            be = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) be = legal_be(be) ? be : 4'hF;
            txn("rand", 1'($urandom_range(0, 1)), a, $urandom, be, 1'b0);
        end

        do_reset();
        txn("postrst", 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT, default 2, wait-state cycles per transaction when DM_WAIT_STATE_EN is defined.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  1  initiator request; held high until ready is seen.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2].
REQ-008 SHALL have port wdata  input  32  write data, lanes aligned to byte position.
REQ-009 SHALL have port byteen  input  4  byte-lane enables for writes; ignored on reads.
REQ-010 SHALL have port pc  input  32  initiator PC, used only for the write log.
REQ-011 SHALL have port ready  output  1  one-cycle response pulse.
REQ-012 SHALL have port rdata  output  32  registered full-word read data.
REQ-013 SHALL have port err  output  1  error flag, valid while ready is high.

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP.
REQ-015 SHALL accept a request at a rising edge in IDLE with req=1, latching we, addr, wdata, byteen, pc.
REQ-016 SHALL go from IDLE to RESP on accept when waits are disabled or WAIT=0; otherwise to WAIT with counter loaded to WAIT.
REQ-017 SHALL decrement the counter each edge in WAIT and go to RESP on the edge where counter equals 1.
REQ-018 SHALL assert ready only in RESP, for exactly one cycle, then return to IDLE unconditionally.
REQ-019 SHALL ignore req in WAIT and RESP; a request still high in the cycle after RESP is a new transaction.
REQ-020 SHALL commit writes and register rdata on the edge entering RESP; a read therefore returns all earlier completed writes.
REQ-021 SHALL accept byteen patterns 1111, 0011, 1100, 0001, 0010, 0100, 1000 only; others on a write are an error.
REQ-022 SHALL update only enabled lanes; disabled lanes keep their stored bytes.
REQ-023 SHALL flag err when word index >= DEPTH (addr >= DEPTH*4) or on an illegal-byteen write.
REQ-024 SHALL on error perform no write, drive rdata=0, err=1 in RESP.
REQ-025 SHALL drive err=0 and hold rdata at its last value outside RESP.
REQ-026 SHALL on each committed write print "@<pc>: *<addr&~3> <= <merged word>" in 8-digit hex.
REQ-027 SHALL treat addr[1:0] as don't-care for word selection.

Reset
REQ-028 SHALL on reset=1 at an edge enter IDLE, clear counter, ready=0, rdata=0, err=0, and zero every memory word.
REQ-029 SHALL give reset priority over req; a transaction in WAIT or RESP is abandoned with no write and no ready.

Configuration
REQ-030 SHALL use macro DM_WAIT_STATE_EN: defined, WAIT wait cycles per transaction (latency WAIT+1 cycles accept-to-ready); undefined, WAIT ignored and latency is 1 cycle.

Verification
REQ-031 Bench SHALL cover these scenarios:
- Reset, then read addr 0x0 -> ready after 1 cycle (no macro), rdata=0x00000000, err=0.
- Write 0x12345678 to 0x10 with byteen=1111, then read 0x10 -> log "@<pc>: *00000010 <= 12345678"; rdata=0x12345678.
- Then byteen=0100, wdata=0x00AB0000 to 0x12 -> stored 0x12AB5678, 0x12 logged as *00000010.
- Write with byteen=0110 or addr=0x4000 (DEPTH 4096) -> ready with err=1, memory unchanged, no log line.
- With DM_WAIT_STATE_EN, WAIT=2, req at edge E0 -> ready high only between E2 and E3; req held through is ignored until IDLE.
- Reset asserted while in WAIT on a write -> IDLE next edge, no ready, location still 0.
